data_mem_arbiter: RTL

Two-requester arbiter for the single data memory port used by the MEM stage load/store unit. It shares the req/gnt/rvalid data memory interface between requester 0 (the LSU) and requester 1 (a secondary master such as a debug or DMA port). Arbitration is round-robin with request locking, and the block tracks outstanding transactions so each in-order `rvalid` is routed back to the requester that issued it.

---
 rtl/data_mem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter with request locking that shares one req/gnt/rvalid data memory port
// between two requesters and routes in-order responses back through a source-ID FIFO.
module data_mem_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  p0_req_i,
    output logic                  p0_gnt_o,
    output logic                  p0_rvalid_o,
    input  logic [DATA_WIDTH-1:0] p0_addr_i,
    input  logic                  p0_we_i,
    input  logic [DATA_WIDTH-1:0] p0_wdata_i,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,

    input  logic                  p1_req_i,
    output logic                  p1_gnt_o,
    output logic                  p1_rvalid_o,
    input  logic [DATA_WIDTH-1:0] p1_addr_i,
    input  logic                  p1_we_i,
    input  logic [DATA_WIDTH-1:0] p1_wdata_i,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,

    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [DATA_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,

    output logic                  err_o
);

    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTSTANDING);

    logic                       r_lock;
    logic                       r_sel;
    logic                       r_last;
    logic [CntW-1:0]            r_cnt;
    logic [PtrW-1:0]            r_wptr;
    logic [PtrW-1:0]            r_rptr;
    logic [MAX_OUTSTANDING-1:0] r_ids;

    logic w_sel;
    logic w_req_sel;
    logic w_full;
    logic w_empty;
    logic w_hs;
    logic w_pop;
    logic w_head;
    logic w_lock_d;
    logic w_sel_d;

    // Explicit wrap so non-power-of-2 depths stay in range.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
    endfunction

    always_comb begin
        w_sel = 1'b0;
        if (r_lock) begin
            w_sel = r_sel;
        end else if (p0_req_i && !p1_req_i) begin
            w_sel = 1'b0;
        end else if (!p0_req_i && p1_req_i) begin
            w_sel = 1'b1;
        end else if (p0_req_i && p1_req_i) begin
            w_sel = ~r_last;
        end
    end

    assign w_req_sel    = w_sel ? p1_req_i : p0_req_i;
    assign w_full       = (r_cnt == CntFull);
    assign w_empty      = (r_cnt == '0);

    // Full blocks new requests even if a pop lands this cycle: no rvalid-to-req path.
    assign data_req_o   = w_req_sel && !w_full;
    assign data_addr_o  = w_sel ? p1_addr_i  : p0_addr_i;
    assign data_we_o    = w_sel ? p1_we_i    : p0_we_i;
    assign data_wdata_o = w_sel ? p1_wdata_i : p0_wdata_i;

    assign w_hs         = data_req_o && data_gnt_i;
    assign p0_gnt_o     = w_hs && !w_sel;
    assign p1_gnt_o     = w_hs && w_sel;

    assign w_pop        = data_rvalid_i && !w_empty;
    assign w_head       = r_ids[r_rptr];
    assign p0_rvalid_o  = w_pop && !w_head;
    assign p1_rvalid_o  = w_pop && w_head;
    assign p0_rdata_o   = data_rdata_i;
    assign p1_rdata_o   = data_rdata_i;
    assign err_o        = data_rvalid_i && w_empty;

    // A stalled request pins the selection; a dropped locked request releases it.
    always_comb begin
        w_lock_d = r_lock;
        w_sel_d  = r_sel;
        if (w_hs) begin
            w_lock_d = 1'b0;
        end else if (data_req_o) begin
            w_lock_d = 1'b1;
            w_sel_d  = w_sel;
        end else if (r_lock && !w_req_sel) begin
            w_lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock <= 1'b0;
            r_sel  <= 1'b0;
            r_last <= 1'b1;
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_ids  <= '0;
        end else begin
            r_lock <= w_lock_d;
            r_sel  <= w_sel_d;
            if (w_hs) begin
                r_last        <= w_sel;
                r_ids[r_wptr] <= w_sel;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_hs && !w_pop) begin
                r_cnt <= r_cnt + CntW'(1);
            end else if (!w_hs && w_pop) begin
                r_cnt <= r_cnt - CntW'(1);
            end
        end
    end

endmodule
